// File: rtl/hms_pkg.sv
// Shared encodings and helpers for the HMS clock set controller.
// Field indices are bit positions in the inc/dec enables and pair positions in the blink mask.
package hms_pkg;

    typedef enum logic {
        MODE_CLOCK = 1'b0,
        MODE_SETUP = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        POS_SEC  = 2'd0,
        POS_MIN  = 2'd1,
        POS_HOUR = 2'd2
    } pos_e;

    localparam int unsigned FLD_SEC  = 0;
    localparam int unsigned FLD_MIN  = 1;
    localparam int unsigned FLD_HOUR = 2;

    localparam logic [5:0] MASK_ALL = 6'h3F;

    function automatic pos_e next_pos(input pos_e pos);
        unique case (pos)
            POS_SEC:  next_pos = POS_MIN;
            POS_MIN:  next_pos = POS_HOUR;
            default:  next_pos = POS_SEC;
        endcase
    endfunction

    function automatic logic [2:0] fld_onehot(input pos_e pos);
        unique case (pos)
            POS_MIN:  fld_onehot = 3'b1 << FLD_MIN;
            POS_HOUR: fld_onehot = 3'b1 << FLD_HOUR;
            default:  fld_onehot = 3'b1 << FLD_SEC;
        endcase
    endfunction

    // Selected field's digit pair follows ~phase; all other digits stay lit.
    function automatic logic [5:0] setup_mask(input pos_e pos, input logic phase);
        logic [5:0] m;
        m = MASK_ALL;
        unique case (pos)
            POS_MIN:  m[2*FLD_MIN  +: 2] = {2{~phase}};
            POS_HOUR: m[2*FLD_HOUR +: 2] = {2{~phase}};
            default:  m[2*FLD_SEC  +: 2] = {2{~phase}};
        endcase
        return m;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge press detector for a debounced button level.
// History resets to 1 so a button held through reset yields no press.
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic press
);

    logic hist;

    always_ff @(posedge clk) begin
        if (!rst_n) hist <= 1'b1;
        else        hist <= level;
    end

    assign press = level & ~hist;

endmodule

// File: rtl/hms_set_ctrl.sv
// Mode/set controller for the HMS clock: turns buttons and the 1 Hz tick into
// one-cycle counter enables and a digit blink mask. All outputs registered.
module hms_set_ctrl
    import hms_pkg::*;
#(
    parameter int unsigned TIMEOUT_SEC = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_tick_1hz,
    input  logic       i_btn_mode,
    input  logic       i_btn_pos,
    input  logic       i_btn_inc,
    input  logic       i_btn_dec,
    input  logic       i_sec_max,
    input  logic       i_min_max,
    output logic       o_mode,
    output logic [1:0] o_pos,
    output logic [2:0] o_inc,
    output logic [2:0] o_dec,
    output logic [5:0] o_blink_mask
);

    localparam int unsigned IDLE_W = (TIMEOUT_SEC > 0) ? $clog2(TIMEOUT_SEC + 1) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST =
        IDLE_W'((TIMEOUT_SEC > 0) ? TIMEOUT_SEC - 1 : 0);

    logic mode_ev, pos_ev, inc_ev, dec_ev, any_press, timeout;

    btn_edge u_edge_mode (.clk(clk), .rst_n(rst_n), .level(i_btn_mode), .press(mode_ev));
    btn_edge u_edge_pos  (.clk(clk), .rst_n(rst_n), .level(i_btn_pos),  .press(pos_ev));
    btn_edge u_edge_inc  (.clk(clk), .rst_n(rst_n), .level(i_btn_inc),  .press(inc_ev));
    btn_edge u_edge_dec  (.clk(clk), .rst_n(rst_n), .level(i_btn_dec),  .press(dec_ev));

    mode_e             mode_q, mode_d;
    pos_e              pos_q, pos_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              phase_q, phase_d;
    logic [2:0]        inc_d, dec_d;
    logic [5:0]        mask_d;

    assign any_press = mode_ev | pos_ev | inc_ev | dec_ev;
    assign timeout   = (TIMEOUT_SEC > 0) && i_tick_1hz && (idle_q == IDLE_LAST) && !any_press;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q       <= MODE_CLOCK;
            pos_q        <= POS_SEC;
            idle_q       <= '0;
            phase_q      <= 1'b0;
            o_inc        <= '0;
            o_dec        <= '0;
            o_blink_mask <= MASK_ALL;
        end else begin
            mode_q       <= mode_d;
            pos_q        <= pos_d;
            idle_q       <= idle_d;
            phase_q      <= phase_d;
            o_inc        <= inc_d;
            o_dec        <= dec_d;
            o_blink_mask <= mask_d;
        end
    end

    always_comb begin
        mode_d  = mode_q;
        pos_d   = pos_q;
        idle_d  = idle_q;
        phase_d = phase_q;
        inc_d   = '0;
        dec_d   = '0;

        unique case (mode_q)
            MODE_CLOCK: begin
                idle_d  = '0;
                phase_d = 1'b0;
                // A tick coinciding with the mode press still advances time.
                if (i_tick_1hz)
                    inc_d = {i_sec_max & i_min_max, i_sec_max, 1'b1};
                if (mode_ev) begin
                    mode_d = MODE_SETUP;
                    pos_d  = POS_SEC;
                end
            end
            default: begin
                if (any_press) begin
                    idle_d  = '0;
                    phase_d = 1'b0;
                end else if (i_tick_1hz) begin
                    idle_d  = idle_q + IDLE_W'(1);
                    phase_d = ~phase_q;
                end

                if (mode_ev || timeout) begin
                    mode_d  = MODE_CLOCK;
                    idle_d  = '0;
                    phase_d = 1'b0;
                end else if (pos_ev) begin
                    pos_d = next_pos(pos_q);
                end else if (inc_ev ^ dec_ev) begin
                    if (inc_ev) inc_d = fld_onehot(pos_q);
                    else        dec_d = fld_onehot(pos_q);
                end
            end
        endcase

        mask_d = (mode_d == MODE_SETUP) ? setup_mask(pos_d, phase_d) : MASK_ALL;
    end

    assign o_mode = mode_q;
    assign o_pos  = pos_q;

endmodule

// File: tb/tb_hms_set_ctrl.sv
// Directed self-checking bench for hms_set_ctrl with hand-computed expectations.
module tb_hms_set_ctrl;

    logic       clk;
    logic       rst_n;
    logic       i_tick_1hz, i_btn_mode, i_btn_pos, i_btn_inc, i_btn_dec;
    logic       i_sec_max, i_min_max;
    logic       o_mode;
    logic [1:0] o_pos;
    logic [2:0] o_inc, o_dec;
    logic [5:0] o_blink_mask;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    hms_set_ctrl #(.TIMEOUT_SEC(10)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_tick_1hz   (i_tick_1hz),
        .i_btn_mode   (i_btn_mode),
        .i_btn_pos    (i_btn_pos),
        .i_btn_inc    (i_btn_inc),
        .i_btn_dec    (i_btn_dec),
        .i_sec_max    (i_sec_max),
        .i_min_max    (i_min_max),
        .o_mode       (o_mode),
        .o_pos        (o_pos),
        .o_inc        (o_inc),
        .o_dec        (o_dec),
        .o_blink_mask (o_blink_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock and settle just after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_pulse();
        i_tick_1hz = 1'b1;
        step();
        i_tick_1hz = 1'b0;
        step();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_mode"}, {7'd0, o_mode}, 8'h00);
        check({tag, "_pos"},  {6'd0, o_pos},  8'h00);
        check({tag, "_inc"},  {5'd0, o_inc},  8'h00);
        check({tag, "_dec"},  {5'd0, o_dec},  8'h00);
        check({tag, "_mask"}, {2'd0, o_blink_mask}, 8'h3F);
    endtask

    initial begin
        rst_n = 1'b0;
        i_tick_1hz = 1'b0; i_btn_mode = 1'b1; i_btn_pos = 1'b0;
        i_btn_inc = 1'b0;  i_btn_dec = 1'b0;
        i_sec_max = 1'b0;  i_min_max = 1'b0;
        step(); step();
        check_reset_vals("rst");

        // Mode held through reset: no event on release of reset.
        rst_n = 1'b1;
        step();
        check("held_mode", {7'd0, o_mode}, 8'h00);
        i_btn_mode = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            i_tick_1hz = 1'b1;
            step();
            check("clk_tick_inc", {5'd0, o_inc}, 8'h01);
            i_tick_1hz = 1'b0;
            step();
            check("clk_tick_idle", {5'd0, o_inc}, 8'h00);
        end
        check("clk_mode_still0", {7'd0, o_mode}, 8'h00);

        // Full carry chain.
        i_sec_max = 1'b1; i_min_max = 1'b1; i_tick_1hz = 1'b1;
        step();
        check("carry_all", {5'd0, o_inc}, 8'h07);
        i_tick_1hz = 1'b0;
        step();
        check("carry_once", {5'd0, o_inc}, 8'h00);
        i_sec_max = 1'b0;
        i_tick_1hz = 1'b1;
        step();
        check("carry_min_only_gated", {5'd0, o_inc}, 8'h01);
        i_tick_1hz = 1'b0; i_min_max = 1'b0;
        step();

        // Buttons ignored in CLOCK.
        i_btn_inc = 1'b1;
        step();
        check("clk_inc_ignored", {5'd0, o_inc}, 8'h00);
        i_btn_inc = 1'b0;
        step();

        // Enter SETUP, select HOUR, increment it.
        i_btn_mode = 1'b1;
        step();
        check("enter_mode", {7'd0, o_mode}, 8'h01);
        check("enter_pos", {6'd0, o_pos}, 8'h00);
        check("enter_mask", {2'd0, o_blink_mask}, 8'h3F);
        i_btn_mode = 1'b0; step();
        i_btn_pos = 1'b1; step();
        check("pos_min", {6'd0, o_pos}, 8'h01);
        i_btn_pos = 1'b0; step();
        i_btn_pos = 1'b1; step();
        check("pos_hour", {6'd0, o_pos}, 8'h02);
        i_btn_pos = 1'b0; step();
        i_btn_inc = 1'b1; step();
        check("set_inc_hour", {5'd0, o_inc}, 8'h04);
        step();
        check("set_inc_held", {5'd0, o_inc}, 8'h00);
        i_btn_inc = 1'b0; step();
        i_tick_1hz = 1'b1; step();
        check("set_tick_noinc", {5'd0, o_inc}, 8'h00);
        check("blink_off", {2'd0, o_blink_mask}, 8'h0F);
        i_tick_1hz = 1'b0; step();
        check("blink_hold", {2'd0, o_blink_mask}, 8'h0F);
        i_tick_1hz = 1'b1; step();
        check("blink_on", {2'd0, o_blink_mask}, 8'h3F);
        i_tick_1hz = 1'b0; step();

        // Wrap HOUR -> SEC -> MIN, then inc/dec cancel, then dec.
        i_btn_pos = 1'b1; step();
        check("pos_wrap", {6'd0, o_pos}, 8'h00);
        i_btn_pos = 1'b0; step();
        i_btn_pos = 1'b1; step();
        i_btn_pos = 1'b0; step();
        check("pos_min2", {6'd0, o_pos}, 8'h01);
        i_btn_inc = 1'b1; i_btn_dec = 1'b1; step();
        check("cancel_inc", {5'd0, o_inc}, 8'h00);
        check("cancel_dec", {5'd0, o_dec}, 8'h00);
        i_btn_inc = 1'b0; i_btn_dec = 1'b0; step();
        i_btn_dec = 1'b1; step();
        check("dec_min", {5'd0, o_dec}, 8'h02);
        i_btn_dec = 1'b0; step();
        check("dec_once", {5'd0, o_dec}, 8'h00);

        // Leave, re-enter SETUP, then exercise the timeout.
        i_btn_mode = 1'b1; step();
        check("exit_mode", {7'd0, o_mode}, 8'h00);
        check("exit_pos_kept", {6'd0, o_pos}, 8'h01);
        i_btn_mode = 1'b0; step();
        i_btn_mode = 1'b1; step();
        check("reenter_pos", {6'd0, o_pos}, 8'h00);
        i_btn_mode = 1'b0; step();
        for (int i = 0; i < 5; i++) tick_pulse();
        check("to_pre_press", {7'd0, o_mode}, 8'h01);
        i_btn_inc = 1'b1; step();
        check("to_inc_sec", {5'd0, o_inc}, 8'h01);
        i_btn_inc = 1'b0; step();
        for (int i = 0; i < 9; i++) tick_pulse();
        check("to_before", {7'd0, o_mode}, 8'h01);
        i_tick_1hz = 1'b1; step();
        check("to_fired", {7'd0, o_mode}, 8'h00);
        check("to_noinc", {5'd0, o_inc}, 8'h00);
        check("to_mask", {2'd0, o_blink_mask}, 8'h3F);
        i_tick_1hz = 1'b0; step();

        // Mode press with tick in CLOCK, then reset mid-SETUP drops pending tick.
        i_btn_mode = 1'b1; i_tick_1hz = 1'b1; step();
        check("coinc_inc", {5'd0, o_inc}, 8'h01);
        check("coinc_mode", {7'd0, o_mode}, 8'h01);
        i_btn_mode = 1'b0;
        rst_n = 1'b0; step();
        check_reset_vals("midrst");
        i_tick_1hz = 1'b0;
        rst_n = 1'b1; step();
        check_reset_vals("postrst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
